mem_stage_multilane: RTL and testbench

- Parametrised N-lane successor of the dual-issue memory-access stage. Sits between the EX and WB stages.
- Registers a group of up to LANES instructions and waits for the single data-SRAM response of the group's load, if it has one.
- Releases the whole group to WB together.
- After an exception flush, counts the load responses still owed to killed instructions and silently drops them, so stale data never reaches a later load.

---
 rtl/mem_stage_multilane_if.sv | 38 +++
 rtl/mem_stage_multilane.sv | 132 +++++++++++++
 tb/tb_mem_stage_multilane.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_multilane_if.sv
// EX/MEM/WB-facing signal bundle of the multi-lane memory-access stage.
// The stage itself sits on the slave modport; whatever drives EX, WB and the SRAM side uses master.
interface mem_stage_multilane_if #(
  parameter int LANES           = 2,
  parameter int PAYLOAD_W       = 64,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic                                 next_allowin_i;
  logic [LANES-1:0]                     pre_to_now_valid_i;
  logic [LANES-1:0]                     pre_is_load_i;
  logic [LANES*PAYLOAD_W-1:0]           pre_to_ibus;
  logic                                 now_allowin_o;
  logic [LANES-1:0]                     now_to_next_valid_o;
  logic                                 excep_flush_i;
  logic                                 data_sram_data_ok_i;
  logic [DATA_W-1:0]                    mem_rdata_i;
  logic [LANES*(PAYLOAD_W+DATA_W)-1:0]  to_next_obus;
  logic                                 load_pending_o;
  logic [CW-1:0]                        discard_cnt_o;
  logic                                 overflow_o;

  modport master (
    output next_allowin_i, pre_to_now_valid_i, pre_is_load_i, pre_to_ibus,
           excep_flush_i, data_sram_data_ok_i, mem_rdata_i,
    input  now_allowin_o, now_to_next_valid_o, to_next_obus,
           load_pending_o, discard_cnt_o, overflow_o
  );

  modport slave (
    input  next_allowin_i, pre_to_now_valid_i, pre_is_load_i, pre_to_ibus,
           excep_flush_i, data_sram_data_ok_i, mem_rdata_i,
    output now_allowin_o, now_to_next_valid_o, to_next_obus,
           load_pending_o, discard_cnt_o, overflow_o
  );
endinterface

// File: rtl/mem_stage_multilane.sv
// N-lane MEM stage: holds one issue group until its (single) load response arrives,
// releases the group to WB as a unit, and drops responses owed to flushed loads.
module mem_stage_lane #(
  parameter int PAYLOAD_W = 64,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_en,
  input  logic                        flush,
  input  logic                        capture,
  input  logic                        pre_valid,
  input  logic                        pre_is_load,
  input  logic [PAYLOAD_W-1:0]        pre_payload,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        valid,
  output logic                        pending,
  output logic                        done,
  output logic [PAYLOAD_W+DATA_W-1:0] obus
);
  logic                 valid_q, is_load_q, got_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [DATA_W-1:0]    rdata_q;

  // rdata_q is cleared on every load so non-load lanes present zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      is_load_q <= 1'b0;
      got_q     <= 1'b0;
      payload_q <= '0;
      rdata_q   <= '0;
    end else if (load_en) begin
      valid_q   <= pre_valid;
      is_load_q <= pre_is_load;
      payload_q <= pre_payload;
      rdata_q   <= '0;
      got_q     <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      got_q   <= 1'b0;
    end else if (capture) begin
      rdata_q <= mem_rdata;
      got_q   <= 1'b1;
    end
  end

  assign valid   = valid_q;
  assign pending = valid_q & is_load_q & ~got_q;
  assign done    = ~valid_q | ~is_load_q | got_q | capture;
  assign obus    = {(capture ? mem_rdata : rdata_q), payload_q};
endmodule

module mem_stage_multilane #(
  parameter int LANES           = 2,
  parameter int PAYLOAD_W       = 64,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_stage_multilane_if.slave   bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int OW = PAYLOAD_W + DATA_W;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [LANES-1:0][PAYLOAD_W-1:0] pre_pay;
  logic [LANES-1:0][OW-1:0]        lane_obus;
  logic [LANES-1:0]                lane_vld, lane_pend, lane_done, capture;
  logic [CW-1:0]                   discard_q;
  logic                            overflow_q;
  logic                            flush, stale, route, group_done, fire, allowin, load_en, owed, inc;

  assign pre_pay = bus.pre_to_ibus;
  assign flush   = bus.excep_flush_i;

  // Stale responses are always ahead of live ones, so the counter decides routing.
  assign stale   = bus.data_sram_data_ok_i & (discard_q != '0);
  assign route   = bus.data_sram_data_ok_i & (discard_q == '0);
  assign capture = {LANES{route}} & lane_pend;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mem_stage_lane #(.PAYLOAD_W(PAYLOAD_W), .DATA_W(DATA_W)) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_en     (load_en),
      .flush       (flush),
      .capture     (capture[g]),
      .pre_valid   (bus.pre_to_now_valid_i[g]),
      .pre_is_load (bus.pre_is_load_i[g]),
      .pre_payload (pre_pay[g]),
      .mem_rdata   (bus.mem_rdata_i),
      .valid       (lane_vld[g]),
      .pending     (lane_pend[g]),
      .done        (lane_done[g]),
      .obus        (lane_obus[g])
    );
  end

  assign group_done = &lane_done;
  assign fire       = group_done & bus.next_allowin_i & ~flush;
  assign allowin    = ~(|lane_vld) | fire;
  assign load_en    = allowin & ~flush;

  // A flushed load whose response did not land this cycle still owes one response.
  assign owed = (|lane_pend) & ~(|capture);
  assign inc  = flush & owed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      case ({inc, stale})
        2'b10: begin
          if (discard_q == MAX_CNT) overflow_q <= 1'b1;
          else                      discard_q  <= discard_q + 1'b1;
        end
        2'b01:   discard_q <= discard_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.now_allowin_o       = allowin;
  assign bus.now_to_next_valid_o = lane_vld & {LANES{fire}};
  assign bus.to_next_obus        = lane_obus;
  assign bus.load_pending_o      = |lane_pend;
  assign bus.discard_cnt_o       = discard_q;
  assign bus.overflow_o          = overflow_q;
endmodule

// File: tb/tb_mem_stage_multilane.sv
// Bench for mem_stage_multilane: directed cycle table, queue-based random model, and a
// saturation/async-reset sequence on a MAX_OUTSTANDING=1 instance.
module tb_mem_stage_multilane;
  localparam int L = 2, PW = 64, DW = 32, MO = 4, CW = $clog2(MO + 1), OW = PW + DW;

  logic clk = 1'b0;
  logic rst_n, rst2_n;
  always #5 clk = ~clk;

  mem_stage_multilane_if #(.LANES(L), .PAYLOAD_W(PW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) bus ();
  mem_stage_multilane_if #(.LANES(L), .PAYLOAD_W(PW), .DATA_W(DW), .MAX_OUTSTANDING(1))  bus2 ();

  mem_stage_multilane #(.LANES(L), .PAYLOAD_W(PW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  mem_stage_multilane #(.LANES(L), .PAYLOAD_W(PW), .DATA_W(DW), .MAX_OUTSTANDING(1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2.slave));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic na, input logic [L-1:0] pv, input logic [L-1:0] pl,
                       input logic fl, input logic dok, input logic [DW-1:0] rd,
                       input logic [L*PW-1:0] pb);
    bus.next_allowin_i = na;  bus.pre_to_now_valid_i = pv; bus.pre_is_load_i = pl;
    bus.excep_flush_i  = fl;  bus.data_sram_data_ok_i = dok; bus.mem_rdata_i = rd;
    bus.pre_to_ibus    = pb;
  endtask

  task automatic drive2(input logic na, input logic [L-1:0] pv, input logic [L-1:0] pl,
                        input logic fl);
    bus2.next_allowin_i = na;  bus2.pre_to_now_valid_i = pv; bus2.pre_is_load_i = pl;
    bus2.excep_flush_i  = fl;  bus2.data_sram_data_ok_i = 1'b0; bus2.mem_rdata_i = '0;
    bus2.pre_to_ibus    = {64'h2222_0000_0000_0001, 64'h1111_0000_0000_0000};
  endtask

  // One row per cycle: inputs, then the outputs expected before the following edge.
  typedef struct {
    logic na; logic [1:0] pv, pl; logic fl, dok; logic [31:0] rd; logic [63:0] pay;
    logic e_allow; logic [1:0] e_vld; logic e_pend; logic [2:0] e_disc;
    logic [31:0] e_rd1; logic [63:0] e_pay0;
  } vec_t;

  vec_t tv[23];

  function automatic vec_t v(logic na, logic [1:0] pv, logic [1:0] pl, logic fl, logic dok,
                             logic [31:0] rd, logic [63:0] pay, logic ea, logic [1:0] ev,
                             logic ep, logic [2:0] ed, logic [31:0] er, logic [63:0] epay);
    vec_t t;
    t.na = na; t.pv = pv; t.pl = pl; t.fl = fl; t.dok = dok; t.rd = rd; t.pay = pay;
    t.e_allow = ea; t.e_vld = ev; t.e_pend = ep; t.e_disc = ed; t.e_rd1 = er; t.e_pay0 = epay;
    return t;
  endfunction

  localparam logic [63:0] PA = 64'hA000_0000_0000_000A, PB = 64'hB000_0000_0000_000B,
                          PC = 64'hC000_0000_0000_000C, PD = 64'hD000_0000_0000_000D,
                          PE = 64'hE000_0000_0000_000E, PF = 64'hF000_0000_0000_000F,
                          PG = 64'h6000_0000_0000_0006;

  // Behavioural model: one group record plus an in-order queue of owed responses
  // (1 = owner was flushed, 0 = owner is the group currently in the stage).
  logic [L-1:0]  m_vld;
  int            m_ld;
  logic [PW-1:0] m_pay[L];
  logic          m_got;
  logic [DW-1:0] m_rd;
  bit            rq[$];

  function automatic int killed_cnt();
    int c = 0;
    foreach (rq[k]) if (rq[k]) c++;
    return c;
  endfunction

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0);
    drive2(1'b1, '0, '0, 1'b0);
    tv[0]  = v(1, 2'b11, 2'b00, 0, 0, 0,            PA, 1, 2'b00, 0, 0, 0,            0);
    tv[1]  = v(1, 2'b00, 2'b00, 0, 0, 0,            0,  1, 2'b11, 0, 0, 0,            PA);
    tv[2]  = v(1, 2'b11, 2'b10, 0, 0, 0,            PB, 1, 2'b00, 0, 0, 0,            0);
    tv[3]  = v(1, 2'b00, 2'b00, 0, 0, 0,            0,  0, 2'b00, 1, 0, 0,            0);
    tv[4]  = v(1, 2'b00, 2'b00, 0, 0, 0,            0,  0, 2'b00, 1, 0, 0,            0);
    tv[5]  = v(1, 2'b00, 2'b00, 0, 0, 0,            0,  0, 2'b00, 1, 0, 0,            0);
    tv[6]  = v(1, 2'b00, 2'b00, 0, 1, 32'hDEADBEEF, 0,  1, 2'b11, 1, 0, 32'hDEADBEEF, PB);
    tv[7]  = v(1, 2'b11, 2'b10, 0, 0, 0,            PC, 1, 2'b00, 0, 0, 0,            0);
    tv[8]  = v(0, 2'b00, 2'b00, 0, 1, 32'hDEADBEEF, 0,  0, 2'b00, 1, 0, 0,            0);
    tv[9]  = v(0, 2'b00, 2'b00, 0, 0, 0,            0,  0, 2'b00, 0, 0, 0,            0);
    tv[10] = v(0, 2'b00, 2'b00, 0, 0, 0,            0,  0, 2'b00, 0, 0, 0,            0);
    tv[11] = v(0, 2'b00, 2'b00, 0, 0, 0,            0,  0, 2'b00, 0, 0, 0,            0);
    tv[12] = v(1, 2'b00, 2'b00, 0, 0, 0,            0,  1, 2'b11, 0, 0, 32'hDEADBEEF, PC);
    tv[13] = v(1, 2'b11, 2'b10, 0, 0, 0,            PD, 1, 2'b00, 0, 0, 0,            0);
    tv[14] = v(1, 2'b11, 2'b10, 1, 0, 0,            PE, 0, 2'b00, 1, 0, 0,            0);
    tv[15] = v(1, 2'b00, 2'b00, 0, 0, 0,            0,  1, 2'b00, 0, 1, 0,            0);
    tv[16] = v(1, 2'b11, 2'b10, 0, 0, 0,            PF, 1, 2'b00, 0, 1, 0,            0);
    tv[17] = v(1, 2'b00, 2'b00, 0, 1, 32'h11111111, 0,  0, 2'b00, 1, 1, 0,            0);
    tv[18] = v(1, 2'b00, 2'b00, 0, 1, 32'h22222222, 0,  1, 2'b11, 1, 0, 32'h22222222, PF);
    tv[19] = v(1, 2'b11, 2'b10, 0, 0, 0,            PG, 1, 2'b00, 0, 0, 0,            0);
    tv[20] = v(1, 2'b00, 2'b00, 1, 1, 32'h33333333, 0,  0, 2'b00, 1, 0, 0,            0);
    tv[21] = v(1, 2'b00, 2'b00, 0, 0, 0,            0,  1, 2'b00, 0, 0, 0,            0);
    tv[22] = v(1, 2'b00, 2'b00, 0, 0, 0,            0,  1, 2'b00, 0, 0, 0,            0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst allowin", bus.now_allowin_o, 1);
    chk("rst valid",   bus.now_to_next_valid_o, 0);
    chk("rst pending", bus.load_pending_o, 0);
    chk("rst discard", bus.discard_cnt_o, 0);
    chk("rst overflow", bus.overflow_o, 0);
    @(negedge clk); rst_n = 1'b1; rst2_n = 1'b1;

    for (int r = 0; r < 23; r++) begin
      @(negedge clk);
      drive(tv[r].na, tv[r].pv, tv[r].pl, tv[r].fl, tv[r].dok, tv[r].rd, {~tv[r].pay, tv[r].pay});
      #1;
      chk($sformatf("r%0d allowin", r), bus.now_allowin_o, tv[r].e_allow);
      chk($sformatf("r%0d valid", r),   bus.now_to_next_valid_o, tv[r].e_vld);
      chk($sformatf("r%0d pending", r), bus.load_pending_o, tv[r].e_pend);
      chk($sformatf("r%0d discard", r), bus.discard_cnt_o, tv[r].e_disc);
      if (tv[r].e_vld != 2'b00) begin
        chk($sformatf("r%0d pay0", r), bus.to_next_obus[0 +: PW], tv[r].e_pay0);
        chk($sformatf("r%0d pay1", r), bus.to_next_obus[OW +: PW], ~tv[r].e_pay0);
        chk($sformatf("r%0d rd0", r),  bus.to_next_obus[PW +: DW], 0);
        chk($sformatf("r%0d rd1", r),  bus.to_next_obus[OW+PW +: DW], tv[r].e_rd1);
      end
    end

    // Random phase; the directed table leaves the stage empty with nothing owed.
    m_vld = '0; m_ld = -1; m_got = 1'b0; m_rd = '0;
    for (int c = 0; c < 1500; c++) begin
      logic na, fl, dok, has_pend, fresh, done, fire, exp_allow;
      logic [L-1:0] pv, pl, exp_vld;
      logic [DW-1:0] rd;
      logic [PW-1:0] pay[L];
      logic [L*PW-1:0] pb;
      int ll;
      pv = L'($urandom_range(0, (1 << L) - 1));
      ll = $urandom_range(0, L - 1);
      pl = (pv[ll] && $urandom_range(0, 1) == 1) ? L'(1 << ll) : '0;
      na  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 9) == 0) && (killed_cnt() < MO);
      dok = (rq.size() > 0) && ($urandom_range(0, 4) < 2);
      rd  = $urandom;
      for (int i = 0; i < L; i++) begin
        pay[i] = {$urandom, $urandom};
        pb[i*PW +: PW] = pay[i];
      end
      @(negedge clk);
      drive(na, pv, pl, fl, dok, rd, pb);
      #1;
      has_pend  = (m_vld != '0) && (m_ld >= 0) && !m_got;
      fresh     = dok && !rq[0];
      done      = !has_pend || fresh;
      fire      = (m_vld != '0) && done && na && !fl;
      exp_allow = (m_vld == '0) || (done && na && !fl);
      exp_vld   = fire ? m_vld : '0;
      chk($sformatf("c%0d allowin", c), bus.now_allowin_o, exp_allow);
      chk($sformatf("c%0d valid", c),   bus.now_to_next_valid_o, exp_vld);
      chk($sformatf("c%0d pending", c), bus.load_pending_o, has_pend);
      chk($sformatf("c%0d discard", c), bus.discard_cnt_o, killed_cnt());
      if (fire) begin
        for (int i = 0; i < L; i++) begin
          if (m_vld[i]) begin
            chk($sformatf("c%0d pay%0d", c, i), bus.to_next_obus[i*OW +: PW], m_pay[i]);
            chk($sformatf("c%0d rd%0d", c, i), bus.to_next_obus[i*OW+PW +: DW],
                (i == m_ld) ? (m_got ? m_rd : rd) : '0);
          end
        end
      end
      if (dok) begin
        void'(rq.pop_front());
        if (fresh) begin m_got = 1'b1; m_rd = rd; end
      end
      if (fl) begin
        if (has_pend && !fresh) rq[rq.size() - 1] = 1'b1;
        m_vld = '0; m_got = 1'b0;
      end else if (exp_allow) begin
        m_vld = pv; m_got = 1'b0;
        m_ld = (pl != '0) ? ll : -1;
        for (int i = 0; i < L; i++) m_pay[i] = pay[i];
        if (pl != '0) rq.push_back(1'b0);
      end
    end
    @(negedge clk); drive(1'b1, '0, '0, 1'b0, 1'b0, '0, '0);

    // Saturation at MAX_OUTSTANDING=1, then async reset in mid-cycle.
    @(negedge clk); drive2(1'b1, 2'b01, 2'b01, 1'b0); #1;
    chk("sat accept0", bus2.now_allowin_o, 1);
    @(negedge clk); drive2(1'b1, 2'b00, 2'b00, 1'b1); #1;
    chk("sat pend0", bus2.load_pending_o, 1);
    chk("sat disc0", bus2.discard_cnt_o, 0);
    @(negedge clk); drive2(1'b1, 2'b01, 2'b01, 1'b0); #1;
    chk("sat disc1", bus2.discard_cnt_o, 1);
    chk("sat accept1", bus2.now_allowin_o, 1);
    chk("sat ovf0", bus2.overflow_o, 0);
    @(negedge clk); drive2(1'b1, 2'b00, 2'b00, 1'b1); #1;
    chk("sat pend1", bus2.load_pending_o, 1);
    @(negedge clk); drive2(1'b1, 2'b11, 2'b01, 1'b0); #1;
    chk("sat disc2", bus2.discard_cnt_o, 1);
    chk("sat ovf1", bus2.overflow_o, 1);
    chk("sat accept2", bus2.now_allowin_o, 1);
    @(negedge clk); drive2(1'b0, 2'b00, 2'b00, 1'b0); #1;
    chk("sat pend2", bus2.load_pending_o, 1);
    chk("sat hold", bus2.now_allowin_o, 0);
    #2 rst2_n = 1'b0;
    #1;
    chk("arst allowin", bus2.now_allowin_o, 1);
    chk("arst valid",   bus2.now_to_next_valid_o, 0);
    chk("arst pending", bus2.load_pending_o, 0);
    chk("arst discard", bus2.discard_cnt_o, 0);
    chk("arst overflow", bus2.overflow_o, 0);
    @(negedge clk); rst2_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
